// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and defaults for the parametrised register file
//
// Purpose: sweep-sequencer state type and default sizing constants shared by
//          the register file top, its sweep sequencer and its bus interface.
// Ports:   none (package).

package reg_file_pkg;

  localparam int DW_DEF     = 32;
  localparam int NREG_DEF   = 16;
  localparam int PC_INC_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage : reg_file_pkg

// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - request/response bus between decode/writeback and the register file
//
// Purpose: groups the read selects, write/clear/PC requests, sweep request and
//          the register file responses into one bundle.
// Signals: RSEL (NRD*AW) read selects, RDATA (NRD*DW) read data,
//          WE/WSEL/WDATA write request, CE/CSEL clear request,
//          PC_EN PC increment, CLRALL_REQ sweep request,
//          BUSY sweep in progress, PC_OUT program-counter contents.
// Modports: master = requester side, slave = register file side.

interface reg_file_param_if #(
  parameter int DW   = 32,
  parameter int NREG = 16,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
);

  logic [NRD*AW-1:0] RSEL;
  logic [NRD*DW-1:0] RDATA;
  logic              WE;
  logic [AW-1:0]     WSEL;
  logic [DW-1:0]     WDATA;
  logic              CE;
  logic [AW-1:0]     CSEL;
  logic              PC_EN;
  logic              CLRALL_REQ;
  logic              BUSY;
  logic [DW-1:0]     PC_OUT;

  modport master (
    output RSEL, WE, WSEL, WDATA, CE, CSEL, PC_EN, CLRALL_REQ,
    input  RDATA, BUSY, PC_OUT
  );

  modport slave (
    input  RSEL, WE, WSEL, WDATA, CE, CSEL, PC_EN, CLRALL_REQ,
    output RDATA, BUSY, PC_OUT
  );

endinterface : reg_file_param_if

// File: rtl/reg_file_sweep.sv
// rtl/reg_file_sweep.sv - clear-all sweep sequencer for the register file
//
// Purpose: on a sampled CLRALL_REQ in IDLE, walks an index from 0 to NREG-1,
//          one register per cycle, then returns to IDLE.
// Ports:   CLK         clock, rising edge
//          CLR         asynchronous active-high reset
//          CLRALL_REQ  start request (level, sampled in IDLE only)
//          BUSY        sweep in progress
//          sweep_en    clear reg[sweep_idx] at this edge
//          sweep_idx   index being cleared this cycle

module reg_file_sweep
  import reg_file_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          CLRALL_REQ,
  output logic          BUSY,
  output logic          sweep_en,
  output logic [AW-1:0] sweep_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  sweep_state_e  state;
  sweep_state_e  stateNext;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cntNext;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (CLRALL_REQ) begin
          stateNext = SWEEP;
          cntNext   = '0;
        end
      end
      SWEEP: begin
        // Requests arriving mid-sweep are ignored; the sweep always runs NREG cycles.
        if (cnt == LAST_IDX) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + AW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign BUSY      = (state == SWEEP);
  assign sweep_en  = (state == SWEEP);
  assign sweep_idx = cnt;

endmodule : reg_file_sweep

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with PC register and clear-all sweep
//
// Purpose: NREG x DW register array with NRD combinational read ports,
//          one synchronous write port (optional write-through bypass),
//          per-register synchronous clear, an auto-incrementing PC register
//          at PC_IDX, and a multi-cycle clear-all sweep.
// Ports:   CLK  clock, rising edge
//          CLR  asynchronous active-high reset
//          bus  reg_file_param_if slave: RSEL/RDATA read ports,
//               WE/WSEL/WDATA write, CE/CSEL clear, PC_EN increment,
//               CLRALL_REQ sweep start, BUSY, PC_OUT

module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int PC_IDX = NREG - 1,
  parameter int PC_INC = PC_INC_DEF
) (
  input  logic           CLK,
  input  logic           CLR,
  reg_file_param_if.slave bus
);

  logic [DW-1:0] regs     [NREG];
  logic [DW-1:0] nextVals [NREG];

  logic          busy;
  logic          sweepEn;
  logic [AW-1:0] sweepIdx;

  reg_file_sweep #(
    .NREG (NREG),
    .AW   (AW)
  ) uSweep (
    .CLK        (CLK),
    .CLR        (CLR),
    .CLRALL_REQ (bus.CLRALL_REQ),
    .BUSY       (busy),
    .sweep_en   (sweepEn),
    .sweep_idx  (sweepIdx)
  );

  // All writeback-side requests are dropped (not queued) while sweeping.
  logic wrOk;
  logic clrOk;
  logic pcOk;

  assign wrOk  = bus.WE    & ~busy;
  assign clrOk = bus.CE    & ~busy;
  assign pcOk  = bus.PC_EN & ~busy;

  // Per-register next value. Priority: clear > write > PC increment > hold.
  for (genvar i = 0; i < NREG; i++) begin : gReg
    localparam logic [AW-1:0] IDX   = AW'(i);
    localparam bit            IS_PC = (i == PC_IDX);

    logic [DW-1:0] nextVal;

    always_comb begin
      nextVal = regs[i];
      if (sweepEn) begin
        if (sweepIdx == IDX) begin
          nextVal = '0;
        end
      end else if (clrOk && (bus.CSEL == IDX)) begin
        nextVal = '0;
      end else if (wrOk && (bus.WSEL == IDX)) begin
        nextVal = bus.WDATA;
      end else if (IS_PC && pcOk) begin
        // Wraps modulo 2^DW by construction of the DW-bit add.
        nextVal = regs[i] + DW'(PC_INC);
      end
    end

    assign nextVals[i] = nextVal;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= nextVals[i];
      end
    end
  end

  // Read ports. Bypass only forwards an accepted write, so it is off during a sweep.
  for (genvar k = 0; k < NRD; k++) begin : gRd
    logic [AW-1:0] sel;
    logic          hit;

    assign sel = bus.RSEL[k*AW +: AW];

    if (BYPASS != 0) begin : gByp
      assign hit = wrOk && (bus.WSEL == sel);
    end else begin : gNoByp
      assign hit = 1'b0;
    end

    assign bus.RDATA[k*DW +: DW] = hit ? bus.WDATA : regs[sel];
  end

  assign bus.BUSY   = busy;
  assign bus.PC_OUT = regs[PC_IDX];

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param (bypass and no-bypass builds)

module tb_reg_file_param;

  localparam int DW   = 32;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int NRD  = 2;
  localparam int PCI  = NREG - 1;

  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  logic [NRD*AW-1:0] rsel;
  logic              we;
  logic [AW-1:0]     wsel;
  logic [DW-1:0]     wdata;
  logic              ce;
  logic [AW-1:0]     csel;
  logic              pcEn;
  logic              clrReq;

  int checks = 0;
  int errors = 0;

  reg_file_param_if #(.DW(DW), .NREG(NREG), .NRD(NRD)) busA ();
  reg_file_param_if #(.DW(DW), .NREG(NREG), .NRD(NRD)) busB ();

  assign busA.RSEL = rsel;    assign busB.RSEL = rsel;
  assign busA.WE = we;        assign busB.WE = we;
  assign busA.WSEL = wsel;    assign busB.WSEL = wsel;
  assign busA.WDATA = wdata;  assign busB.WDATA = wdata;
  assign busA.CE = ce;        assign busB.CE = ce;
  assign busA.CSEL = csel;    assign busB.CSEL = csel;
  assign busA.PC_EN = pcEn;   assign busB.PC_EN = pcEn;
  assign busA.CLRALL_REQ = clrReq;
  assign busB.CLRALL_REQ = clrReq;

  reg_file_param #(.DW(DW), .NREG(NREG), .NRD(NRD), .BYPASS(1), .PC_IDX(PCI), .PC_INC(4))
    dutA (.CLK(CLK), .CLR(CLR), .bus(busA));
  reg_file_param #(.DW(DW), .NREG(NREG), .NRD(NRD), .BYPASS(0), .PC_IDX(PCI), .PC_INC(4))
    dutB (.CLK(CLK), .CLR(CLR), .bus(busB));

  // Behavioural model: register contents plus "sweeping / next index to clear".
  logic [DW-1:0] m [NREG];
  bit            mBusy;
  int            mIdx;

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      foreach (m[i]) m[i] = '0;
      mBusy = 0;
      mIdx  = 0;
    end else if (mBusy) begin
      m[mIdx] = '0;
      mIdx++;
      if (mIdx == NREG) begin
        mBusy = 0;
        mIdx  = 0;
      end
    end else begin
      // Applied lowest priority first so later updates override.
      if (pcEn) m[PCI] = m[PCI] + 32'd4;
      if (we)   m[wsel] = wdata;
      if (ce)   m[csel] = '0;
      if (clrReq) begin
        mBusy = 1;
        mIdx  = 0;
      end
    end
  end

  function automatic logic [DW-1:0] expRead(int k, bit byp);
    logic [AW-1:0] s;
    s = rsel[k*AW +: AW];
    if (byp && !mBusy && we && (wsel == s)) return wdata;
    return m[s];
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int k = 0; k < NRD; k++) begin
      check("rdata_byp", busA.RDATA[k*DW +: DW], expRead(k, 1));
      check("rdata_nobyp", busB.RDATA[k*DW +: DW], expRead(k, 0));
    end
    check("busy_a", {31'b0, busA.BUSY}, {31'b0, mBusy});
    check("busy_b", {31'b0, busB.BUSY}, {31'b0, mBusy});
    check("pc_a", busA.PC_OUT, m[PCI]);
    check("pc_b", busB.PC_OUT, m[PCI]);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we = 0; ce = 0; pcEn = 0; clrReq = 0;
  endtask

  int busyCnt;

  initial begin
    CLR = 1'b1;
    rsel = '0; wsel = '0; wdata = '0; csel = '0;
    idle();
    repeat (2) @(posedge CLK);
    #1 CLR = 1'b0;

    // Asynchronous reset wipes contents with no clock edge.
    we = 1; wsel = 0; wdata = 32'hA5; pcEn = 1;
    tick();
    idle();
    rsel = {4'd15, 4'd0};
    @(negedge CLK);
    check("r0_written", busA.RDATA[31:0], 32'hA5);
    check("pc_first_inc", busA.PC_OUT, 32'd4);
    #2 CLR = 1'b1;
    #1;
    check("clr_r0_a", busA.RDATA[31:0], 32'h0);
    check("clr_r15_a", busA.RDATA[63:32], 32'h0);
    check("clr_pc_a", busA.PC_OUT, 32'h0);
    check("clr_r0_b", busB.RDATA[31:0], 32'h0);
    #1 CLR = 1'b0;
    tick();

    // Write with and without bypass.
    we = 1; wsel = 3; wdata = 32'hDEADBEEF; rsel = {4'd0, 4'd3};
    @(negedge CLK);
    check("bypass_same_cycle", busA.RDATA[31:0], 32'hDEADBEEF);
    check("nobypass_same_cycle", busB.RDATA[31:0], 32'h0);
    tick();
    we = 0;
    @(negedge CLK);
    check("write_next_a", busA.RDATA[31:0], 32'hDEADBEEF);
    check("write_next_b", busB.RDATA[31:0], 32'hDEADBEEF);
    tick();

    // Clear beats write on the same index; independent indices both apply.
    we = 1; wsel = 5; wdata = 32'h55; ce = 1; csel = 5;
    tick();
    idle();
    rsel = {4'd0, 4'd5};
    @(negedge CLK);
    check("clear_beats_write", busA.RDATA[31:0], 32'h0);
    tick();
    we = 1; wsel = 5; wdata = 32'h99;
    tick();
    wsel = 2; wdata = 32'h7; ce = 1; csel = 5;
    tick();
    idle();
    rsel = {4'd2, 4'd5};
    @(negedge CLK);
    check("indep_clear_r5", busA.RDATA[31:0], 32'h0);
    check("indep_write_r2", busA.RDATA[63:32], 32'h7);
    tick();

    // PC increments, wrap, and write beating increment.
    pcEn = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      @(negedge CLK);
      check("pc_seq", busA.PC_OUT, 32'(4 * i));
    end
    pcEn = 0;
    tick();
    we = 1; wsel = 4'(PCI); wdata = 32'hFFFFFFFC;
    tick();
    we = 0; pcEn = 1;
    tick();
    pcEn = 0;
    @(negedge CLK);
    check("pc_wrap", busA.PC_OUT, 32'h0);
    tick();
    we = 1; wsel = 4'(PCI); wdata = 32'h100; pcEn = 1;
    tick();
    idle();
    @(negedge CLK);
    check("pc_write_wins", busA.PC_OUT, 32'h100);
    tick();

    // Full sweep with a dropped write and a second request while busy.
    for (int k = 0; k < NREG; k++) begin
      we = 1; wsel = 4'(k); wdata = 32'(k + 1);
      tick();
    end
    idle();
    clrReq = 1;
    tick();
    clrReq = 0;
    busyCnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (!busA.BUSY) break;
      busyCnt++;
      we = (busyCnt == 2); wsel = 0; wdata = 32'hAA;
      clrReq = (busyCnt == 5);
      rsel = 8'($urandom);
    end
    idle();
    check("sweep_busy_cycles", 32'(busyCnt), 32'd16);
    rsel = {4'd0, 4'd0};
    #1;
    check("r0_after_sweep", busA.RDATA[31:0], 32'h0);
    tick();

    // Reset mid-sweep aborts at once; next write is accepted.
    we = 1; wsel = 7; wdata = 32'h77;
    tick();
    idle();
    clrReq = 1;
    tick();
    clrReq = 0;
    repeat (6) @(negedge CLK);
    rsel = {4'd7, 4'd7};
    #2 CLR = 1'b1;
    #1;
    check("midsweep_busy_a", {31'b0, busA.BUSY}, 32'h0);
    check("midsweep_busy_b", {31'b0, busB.BUSY}, 32'h0);
    check("midsweep_r7", busA.RDATA[63:32], 32'h0);
    #1 CLR = 1'b0;
    tick();
    we = 1; wsel = 1; wdata = 32'h1234;
    tick();
    idle();
    rsel = {4'd0, 4'd1};
    @(negedge CLK);
    check("write_after_abort", busA.RDATA[31:0], 32'h1234);
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      we     = 1'($urandom_range(0, 1));
      ce     = ($urandom_range(0, 3) == 0);
      pcEn   = 1'($urandom_range(0, 1));
      clrReq = ($urandom_range(0, 99) == 0);
      wsel   = 4'($urandom);
      csel   = 4'($urandom);
      wdata  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      rsel   = 8'($urandom);
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_param
